// File: rtl/isp_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : isp_ctrl
//  Purpose  : Frame-level sequencer for the ISP datapath. Selects stage
//             enables and output routing per mode, runs the two-pass AWB
//             flow (statistics pass, then correction pass), holds the
//             white-balance gains between frames, checks the pixel count,
//             times out stalled phases and pulses finish_operation.
//  Revision : 1.0 - initial release
// ============================================================================
module isp_ctrl #(
  parameter int MODE_BIT_CNT = 2,
  parameter int GAIN_BIT_CNT = 10,
  parameter int SIZE_BIT_CNT = 5,
  parameter int TIMEOUT      = 4096
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [MODE_BIT_CNT-1:0] mode,
  input  logic [SIZE_BIT_CNT-1:0] size_i,
  input  logic                    src_valid,
  input  logic                    src_last_pic,
  input  logic                    gain_valid_i,
  input  logic [GAIN_BIT_CNT-1:0] k_r_i,
  input  logic [GAIN_BIT_CNT-1:0] k_g_i,
  input  logic [GAIN_BIT_CNT-1:0] k_b_i,
  input  logic                    sink_last_pic,
  output logic                    busy,
  output logic [1:0]              route_sel,
  output logic [5:0]              stage_en,
  output logic                    frame_req,
  output logic [GAIN_BIT_CNT-1:0] k_r_o,
  output logic [GAIN_BIT_CNT-1:0] k_g_o,
  output logic [GAIN_BIT_CNT-1:0] k_b_o,
  output logic                    gain_load_o,
  output logic                    finish_operation,
  output logic                    err
);

  localparam int CNT_W = SIZE_BIT_CNT + 1;
  // Wide enough to hold 2^size for every representable size value.
  localparam int TGT_W = (1 << SIZE_BIT_CNT) + 1;
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  localparam logic [GAIN_BIT_CNT-1:0] C_GAIN_ONE = GAIN_BIT_CNT'(256);

  localparam logic [1:0] C_ROUTE_RAW  = 2'd0;
  localparam logic [1:0] C_ROUTE_DEN  = 2'd1;
  localparam logic [1:0] C_ROUTE_STAT = 2'd2;
  localparam logic [1:0] C_ROUTE_WB   = 2'd3;

  // stage_en bit order: gamma, wb, gain, mean, den, dem
  localparam logic [5:0] C_EN_NONE  = 6'b000000;
  localparam logic [5:0] C_EN_STAT  = 6'b001111;
  localparam logic [5:0] C_EN_WB    = 6'b110011;
  localparam logic [5:0] C_EN_CLEAN = 6'b000011;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    STAT      = 3'd1,
    WAIT_GAIN = 3'd2,
    REPLAY    = 3'd3,
    RUN       = 3'd4,
    DRAIN     = 3'd5,
    DONE      = 3'd6
  } state_t;

  state_t                  state_q;
  logic [SIZE_BIT_CNT-1:0] size_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [TMO_W-1:0]        tmo_q;

  logic [TGT_W-1:0]        cnt_inc;
  logic [TGT_W-1:0]        cnt_target;
  logic                    cnt_bad;
  logic                    tmo_hit;

  // Pixel-count check on the last beat and idle-timeout detection.
  assign cnt_inc    = TGT_W'(cnt_q) + TGT_W'(1);
  assign cnt_target = TGT_W'(1) << size_q;
  assign cnt_bad    = (cnt_inc != cnt_target);
  assign tmo_hit    = (tmo_q == TMO_W'(TIMEOUT - 1));

  // Sequencer: state, counters and every registered output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= IDLE;
      size_q           <= '0;
      cnt_q            <= '0;
      tmo_q            <= '0;
      busy             <= 1'b0;
      route_sel        <= C_ROUTE_RAW;
      stage_en         <= C_EN_NONE;
      frame_req        <= 1'b0;
      gain_load_o      <= 1'b0;
      finish_operation <= 1'b0;
      err              <= 1'b0;
      k_r_o            <= C_GAIN_ONE;
      k_g_o            <= C_GAIN_ONE;
      k_b_o            <= C_GAIN_ONE;
    end else begin
      frame_req        <= 1'b0;
      gain_load_o      <= 1'b0;
      finish_operation <= 1'b0;

      case (state_q)
        IDLE: begin
          tmo_q <= '0;
          if (start) begin
            size_q <= size_i;
            cnt_q  <= '0;
            err    <= 1'b0;
            busy   <= 1'b1;
            case (mode)
              2'd0: begin
                state_q   <= RUN;
                route_sel <= C_ROUTE_RAW;
                stage_en  <= C_EN_NONE;
              end
              2'd1: begin
                state_q   <= STAT;
                route_sel <= C_ROUTE_STAT;
                stage_en  <= C_EN_STAT;
              end
              2'd2: begin
                // wb reloads the held gains as the pass begins
                state_q     <= RUN;
                route_sel   <= C_ROUTE_WB;
                stage_en    <= C_EN_WB;
                gain_load_o <= 1'b1;
              end
              default: begin
                state_q   <= RUN;
                route_sel <= C_ROUTE_DEN;
                stage_en  <= C_EN_CLEAN;
              end
            endcase
          end
        end

        STAT, RUN: begin
          if (src_valid) begin
            tmo_q <= '0;
            cnt_q <= cnt_q + CNT_W'(1);
            if (src_last_pic) begin
              // A wrong count is flagged but the frame still completes.
              if (cnt_bad) begin
                err <= 1'b1;
              end
              if (state_q == STAT) begin
                state_q <= WAIT_GAIN;
              end else if (sink_last_pic) begin
                state_q          <= DONE;
                finish_operation <= 1'b1;
              end else begin
                state_q <= DRAIN;
              end
            end
          end else if (tmo_hit) begin
            tmo_q            <= '0;
            err              <= 1'b1;
            state_q          <= DONE;
            finish_operation <= 1'b1;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end

        WAIT_GAIN: begin
          // A gain arriving on the timeout cycle still takes priority.
          if (gain_valid_i) begin
            tmo_q       <= '0;
            cnt_q       <= '0;
            k_r_o       <= k_r_i;
            k_g_o       <= k_g_i;
            k_b_o       <= k_b_i;
            frame_req   <= 1'b1;
            gain_load_o <= 1'b1;
            route_sel   <= C_ROUTE_WB;
            stage_en    <= C_EN_WB;
            state_q     <= REPLAY;
          end else if (tmo_hit) begin
            tmo_q            <= '0;
            err              <= 1'b1;
            state_q          <= DONE;
            finish_operation <= 1'b1;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end

        REPLAY: begin
          tmo_q   <= '0;
          cnt_q   <= '0;
          state_q <= RUN;
        end

        DRAIN: begin
          if (sink_last_pic) begin
            tmo_q            <= '0;
            state_q          <= DONE;
            finish_operation <= 1'b1;
          end else if (tmo_hit) begin
            tmo_q            <= '0;
            err              <= 1'b1;
            state_q          <= DONE;
            finish_operation <= 1'b1;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end

        DONE: begin
          tmo_q     <= '0;
          busy      <= 1'b0;
          route_sel <= C_ROUTE_RAW;
          stage_en  <= C_EN_NONE;
          state_q   <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_isp_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_isp_ctrl
//  Purpose  : Self-checking bench for isp_ctrl. Each scenario pushes the
//             expected completion result (err, held gains) when it starts an
//             operation and pops it when finish_operation is observed.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_isp_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [4:0] size_i = 5'd0;
  logic       src_valid = 1'b0;
  logic       src_last_pic = 1'b0;
  logic       gain_valid_i = 1'b0;
  logic [9:0] k_r_i = 10'd0;
  logic [9:0] k_g_i = 10'd0;
  logic [9:0] k_b_i = 10'd0;
  logic       sink_last_pic = 1'b0;
  logic       busy;
  logic [1:0] route_sel;
  logic [5:0] stage_en;
  logic       frame_req;
  logic [9:0] k_r_o, k_g_o, k_b_o;
  logic       gain_load_o;
  logic       finish_operation;
  logic       err;

  typedef struct {
    logic       err;
    logic [9:0] kr;
    logic [9:0] kg;
    logic [9:0] kb;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;

  isp_ctrl #(
    .MODE_BIT_CNT(2), .GAIN_BIT_CNT(10), .SIZE_BIT_CNT(5), .TIMEOUT(4096)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .size_i(size_i),
    .src_valid(src_valid), .src_last_pic(src_last_pic),
    .gain_valid_i(gain_valid_i), .k_r_i(k_r_i), .k_g_i(k_g_i), .k_b_i(k_b_i),
    .sink_last_pic(sink_last_pic), .busy(busy), .route_sel(route_sel),
    .stage_en(stage_en), .frame_req(frame_req), .k_r_o(k_r_o), .k_g_o(k_g_o),
    .k_b_o(k_b_o), .gain_load_o(gain_load_o),
    .finish_operation(finish_operation), .err(err)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic start_op(input logic [1:0] m, input logic [4:0] sz);
    @(negedge clk);
    start = 1'b1; mode = m; size_i = sz;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_beats(input int n, input int last_at, input bit sink_on_last);
    for (int i = 1; i <= n; i++) begin
      src_valid = 1'b1;
      src_last_pic = (i == last_at);
      sink_last_pic = sink_on_last && (i == last_at);
      @(negedge clk);
    end
    src_valid = 1'b0; src_last_pic = 1'b0; sink_last_pic = 1'b0;
  endtask

  task automatic pulse_sink(input int delay);
    repeat (delay - 1) @(negedge clk);
    sink_last_pic = 1'b1;
    @(negedge clk);
    sink_last_pic = 1'b0;
  endtask

  // Bounded wait for finish; reports status and snapshot, then counts extra pulses.
  task automatic wait_finish(input int budget, output bit seen, output int pulses,
                             output int waited, output logic e,
                             output logic [9:0] kr, output logic [9:0] kg,
                             output logic [9:0] kb);
    seen = 1'b0; pulses = 0; waited = 0; e = 1'bx; kr = 'x; kg = 'x; kb = 'x;
    for (int i = 0; i < budget && !seen; i++) begin
      if (finish_operation) begin
        seen = 1'b1; pulses = 1; e = err; kr = k_r_o; kg = k_g_o; kb = k_b_o;
      end else begin
        waited++;
        @(negedge clk);
      end
    end
    if (seen) begin
      repeat (4) begin
        @(negedge clk);
        if (finish_operation) pulses++;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, route_sel, stage_en, frame_req, gain_load_o, finish_operation, err} !== 12'd0)
      $display("FAIL reset_ctrl: got %b required 0",
               {busy, route_sel, stage_en, frame_req, gain_load_o, finish_operation, err});
    else passes++;
    checks++;
    if ({k_r_o, k_g_o, k_b_o} !== {10'd256, 10'd256, 10'd256})
      $display("FAIL reset_gain: got %0d/%0d/%0d required 256/256/256", k_r_o, k_g_o, k_b_o);
    else passes++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Finish handling common to each scenario, written out per caller.
  task automatic test_clean();
    bit seen; int pulses, waited; logic e; logic [9:0] kr, kg, kb; exp_t x;
    exp_q.push_back('{err: 1'b0, kr: k_r_o, kg: k_g_o, kb: k_b_o});
    start_op(2'd3, 5'd4);
    checks++;
    if ({busy, route_sel, stage_en} !== {1'b1, 2'd1, 6'b000011})
      $display("FAIL clean_cfg: got busy=%b route=%0d en=%b required 1/1/000011",
               busy, route_sel, stage_en);
    else passes++;
    send_beats(16, 16, 1'b0);
    pulse_sink(3);
    wait_finish(50, seen, pulses, waited, e, kr, kg, kb);
    x = exp_q.pop_front();
    checks++;
    if (!seen || pulses != 1) $display("FAIL clean_finish: got seen=%0d pulses=%0d required 1/1", seen, pulses);
    else passes++;
    checks++;
    if (e !== x.err) $display("FAIL clean_err: got %b required %b", e, x.err);
    else passes++;
    checks++;
    if (busy !== 1'b0) $display("FAIL clean_busy_end: got %b required 0", busy);
    else passes++;
  endtask

  task automatic test_awb();
    bit seen; int pulses, waited; logic e; logic [9:0] kr, kg, kb; exp_t x;
    exp_q.push_back('{err: 1'b0, kr: 10'd300, kg: 10'd256, kb: 10'd200});
    start_op(2'd1, 5'd2);
    checks++;
    if ({route_sel, stage_en} !== {2'd2, 6'b001111})
      $display("FAIL awb_stat_cfg: got route=%0d en=%b required 2/001111", route_sel, stage_en);
    else passes++;
    send_beats(4, 4, 1'b0);
    repeat (3) @(negedge clk);
    checks++;
    if (frame_req !== 1'b0 || busy !== 1'b1)
      $display("FAIL awb_wait: got frame_req=%b busy=%b required 0/1", frame_req, busy);
    else passes++;
    gain_valid_i = 1'b1; k_r_i = 10'd300; k_g_i = 10'd256; k_b_i = 10'd200;
    @(negedge clk);
    gain_valid_i = 1'b0; k_r_i = 10'd0; k_g_i = 10'd0; k_b_i = 10'd0;
    checks++;
    if ({frame_req, gain_load_o, route_sel, stage_en} !== {1'b1, 1'b1, 2'd3, 6'b110011})
      $display("FAIL awb_replay: got req=%b load=%b route=%0d en=%b required 1/1/3/110011",
               frame_req, gain_load_o, route_sel, stage_en);
    else passes++;
    checks++;
    if ({k_r_o, k_g_o, k_b_o} !== {10'd300, 10'd256, 10'd200})
      $display("FAIL awb_gain_latch: got %0d/%0d/%0d required 300/256/200", k_r_o, k_g_o, k_b_o);
    else passes++;
    @(negedge clk);
    checks++;
    if ({frame_req, gain_load_o} !== 2'b00)
      $display("FAIL awb_pulse_width: got req=%b load=%b required 0/0", frame_req, gain_load_o);
    else passes++;
    send_beats(4, 4, 1'b1);
    wait_finish(50, seen, pulses, waited, e, kr, kg, kb);
    x = exp_q.pop_front();
    checks++;
    if (!seen || pulses != 1) $display("FAIL awb_finish: got seen=%0d pulses=%0d required 1/1", seen, pulses);
    else passes++;
    checks++;
    if ({e, kr, kg, kb} !== {x.err, x.kr, x.kg, x.kb})
      $display("FAIL awb_result: got err=%b k=%0d/%0d/%0d required %b %0d/%0d/%0d",
               e, kr, kg, kb, x.err, x.kr, x.kg, x.kb);
    else passes++;
  endtask

  task automatic test_stored();
    bit seen; int pulses, waited; logic e; logic [9:0] kr, kg, kb; exp_t x;
    exp_q.push_back('{err: 1'b0, kr: 10'd300, kg: 10'd256, kb: 10'd200});
    start_op(2'd2, 5'd2);
    checks++;
    if ({gain_load_o, route_sel, stage_en} !== {1'b1, 2'd3, 6'b110011})
      $display("FAIL stored_entry: got load=%b route=%0d en=%b required 1/3/110011",
               gain_load_o, route_sel, stage_en);
    else passes++;
    checks++;
    if ({k_r_o, k_g_o, k_b_o} !== {10'd300, 10'd256, 10'd200})
      $display("FAIL stored_gain: got %0d/%0d/%0d required 300/256/200", k_r_o, k_g_o, k_b_o);
    else passes++;
    send_beats(4, 4, 1'b0);
    checks++;
    if (gain_load_o !== 1'b0) $display("FAIL stored_load_drop: got %b required 0", gain_load_o);
    else passes++;
    pulse_sink(2);
    wait_finish(50, seen, pulses, waited, e, kr, kg, kb);
    x = exp_q.pop_front();
    checks++;
    if (!seen || {e, kr, kg, kb} !== {x.err, x.kr, x.kg, x.kb})
      $display("FAIL stored_result: got seen=%0d err=%b k=%0d/%0d/%0d required 1 %b %0d/%0d/%0d",
               seen, e, kr, kg, kb, x.err, x.kr, x.kg, x.kb);
    else passes++;
  endtask

  task automatic test_bypass_mismatch();
    bit seen; int pulses, waited; logic e; logic [9:0] kr, kg, kb; exp_t x;
    exp_q.push_back('{err: 1'b1, kr: k_r_o, kg: k_g_o, kb: k_b_o});
    start_op(2'd0, 5'd3);
    checks++;
    if ({busy, route_sel, stage_en} !== {1'b1, 2'd0, 6'b000000})
      $display("FAIL bypass_cfg: got busy=%b route=%0d en=%b required 1/0/000000",
               busy, route_sel, stage_en);
    else passes++;
    send_beats(5, 5, 1'b0);
    checks++;
    if (err !== 1'b1) $display("FAIL bypass_err_set: got %b required 1", err);
    else passes++;
    pulse_sink(2);
    wait_finish(50, seen, pulses, waited, e, kr, kg, kb);
    x = exp_q.pop_front();
    checks++;
    if (!seen || e !== x.err) $display("FAIL bypass_finish: got seen=%0d err=%b required 1 %b", seen, e, x.err);
    else passes++;
    // A fresh start clears the sticky error; 1-pixel frame with sink on the same beat.
    exp_q.push_back('{err: 1'b0, kr: k_r_o, kg: k_g_o, kb: k_b_o});
    start_op(2'd3, 5'd0);
    checks++;
    if (err !== 1'b0) $display("FAIL err_clear: got %b required 0", err);
    else passes++;
    send_beats(1, 1, 1'b1);
    wait_finish(50, seen, pulses, waited, e, kr, kg, kb);
    x = exp_q.pop_front();
    checks++;
    if (!seen || e !== x.err) $display("FAIL single_pix: got seen=%0d err=%b required 1 %b", seen, e, x.err);
    else passes++;
  endtask

  task automatic test_timeout();
    bit seen; int pulses, waited; logic e; logic [9:0] kr, kg, kb; exp_t x;
    test_reset();
    exp_q.push_back('{err: 1'b1, kr: 10'd256, kg: 10'd256, kb: 10'd256});
    start_op(2'd1, 5'd1);
    send_beats(2, 2, 1'b0);
    wait_finish(5000, seen, pulses, waited, e, kr, kg, kb);
    x = exp_q.pop_front();
    checks++;
    if (!seen) $display("FAIL tmo_finish: got no finish within 5000 cycles required pulse");
    else passes++;
    checks++;
    if (waited < 4095 || waited > 4098)
      $display("FAIL tmo_latency: got %0d cycles required about 4096", waited);
    else passes++;
    checks++;
    if ({e, kr, kg, kb} !== {x.err, x.kr, x.kg, x.kb} || busy !== 1'b0)
      $display("FAIL tmo_result: got err=%b k=%0d/%0d/%0d busy=%b required %b %0d/%0d/%0d 0",
               e, kr, kg, kb, busy, x.err, x.kr, x.kg, x.kb);
    else passes++;
  endtask

  task automatic test_start_ignored_and_reset();
    int fin_seen;
    start_op(2'd3, 5'd4);
    send_beats(3, 0, 1'b0);
    start = 1'b1; mode = 2'd0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, route_sel, stage_en} !== {1'b1, 2'd1, 6'b000011})
      $display("FAIL start_ignored: got busy=%b route=%0d en=%b required 1/1/000011",
               busy, route_sel, stage_en);
    else passes++;
    send_beats(2, 0, 1'b0);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy, route_sel, stage_en, frame_req, gain_load_o, finish_operation, err} !== 12'd0 ||
        {k_r_o, k_g_o, k_b_o} !== {10'd256, 10'd256, 10'd256})
      $display("FAIL async_reset: got busy=%b route=%0d en=%b k=%0d required reset values",
               busy, route_sel, stage_en, k_r_o);
    else passes++;
    fin_seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (finish_operation) fin_seen++;
    end
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (finish_operation) fin_seen++;
    end
    checks++;
    if (fin_seen != 0) $display("FAIL reset_no_finish: got %0d pulses required 0", fin_seen);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_clean();
    test_awb();
    test_stored();
    test_bypass_mismatch();
    test_timeout();
    test_start_ignored_and_reset();
    checks++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_drain: got %0d left required 0", exp_q.size());
    else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
